key_event_gen: RTL and testbench
================================

# key_event_gen

Keyboard event conditioner between the PS/2 keyboard decoder and all key consumers (state_control, choose_data_control, fight_data_control). It turns the decoder's held-key bitmap and change strobe into single-cycle, one-hot key pulses for W/S/A/D (up/down/left/right) and Enter (center). Directional keys auto-repeat while held; Enter never repeats. Consumers see exactly one pulse per logical press or repeat tick, never a level.

## Interface
Parameters:
- HOLD_DELAY, 50_000_000: cycles from the directional press pulse request to the first repeat request (0.5 s at 100 MHz); must be ≥2.
- REPEAT_PERIOD, 10_000_000: cycles between subsequent repeat requests; must be ≥2.
- CNT_W, 26: repeat counter width; must satisfy 2^CNT_W > max(HOLD_DELAY, REPEAT_PERIOD).

Ports:
- clk, input, 1: system clock (100 MHz). One clock domain.
- rst, input, 1: reset, synchronous, active-low.
- key_valid, input, 1: decoder change strobe (been_ready), one cycle per make/break.
- last_change, input, 9: scan code of the key that just changed.
- key_down, input, 512: decoder held-key bitmap.
- key_U, output, 1: up pulse (W, 9'h01D).
- key_D, output, 1: down pulse (S, 9'h01B).
- key_L, output, 1: left pulse (A, 9'h01C).
- key_R, output, 1: right pulse (D, 9'h023).
- key_C, output, 1: center pulse (Enter, 9'h05A).

## Operation
- Key index k: C=0, U=1, D=2, L=3, R=4. Registers: held[4:0], pending[4:0], rep_key (index 1–4), rep_state, cnt[CNT_W-1:0], outputs.
- Make: key_valid && last_change==code[k] && key_down[code[k]] && !held[k] → set held[k], set pending[k].
- Typematic re-make (held[k] already 1) is ignored: no pending, and the timer is not restarted.
- Break: key_valid && last_change==code[k] && !key_down[code[k]] → clear held[k]. The pending bit is not cleared, so a short tap still yields one pulse.
- key_valid with any other code: no effect.
- Repeat FSM (directional keys only):
  - IDLE: a make on direction k → rep_key=k, cnt=0, go to DELAY.
  - DELAY: cnt increments. At cnt==HOLD_DELAY-1, set pending[rep_key], cnt=0, go to REPEAT.
  - REPEAT: cnt increments. At cnt==REPEAT_PERIOD-1, set pending[rep_key], cnt=0.
  - DELAY/REPEAT plus a make on a different direction j → rep_key=j, cnt=0, go to DELAY (retarget).
  - DELAY/REPEAT plus a break of rep_key → go to IDLE, cnt=0. A break of any other key leaves the FSM unchanged.
  - An Enter make or break never affects the FSM.
- Arbiter: each cycle, if pending≠0, assert the output for the lowest set index (priority C>U>D>L>R) and clear that pending bit; all other outputs are 0. Outputs are always one-hot or all zero.
- Merging: setting a pending bit that is already set has no further effect. Requests do not queue beyond one per key.

## Timing
- All outputs are registered. Reset value: every output 0; held=0, pending=0, rep_state=IDLE, cnt=0, rep_key=U.
- rst low at any edge clears all state at that edge, including mid-DELAY or mid-REPEAT and any pending requests; no pulse appears in the cycle after release of rst.
- Latency: key_valid sampled at edge N sets pending at edge N. The output is high for exactly one cycle starting at edge N+1, if no higher-priority bit is pending.
- Press pulse for a direction at edge N; first repeat request at edge N+HOLD_DELAY; later requests every REPEAT_PERIOD edges after that.
- Same edge as a make on the same key: the make request and the arbiter grant are independent. The pending bit is set and is not cleared by that edge's grant of another key.
- Same edge as a break of rep_key and a timer terminal count: the break wins and no request is set.
- Same edge as a timer request for rep_key while pending[rep_key] is still set: the requests merge into one pulse.

## Structure
- Shared package key_event_pkg holds:
  - the key scan-code constants (W, A, S, D, ENTER);
  - the key index constants C/U/D/L/R;
  - the repeat FSM state encoding (IDLE, DELAY, REPEAT).
- One sub-module, key_repeat_timer, owns rep_state, rep_key and cnt. It takes the per-key make/break strobes and emits a one-cycle rep_req with rep_key. Make/break decode and the arbiter stay in key_event_gen.

## Test plan
Bench parameters: HOLD_DELAY=8, REPEAT_PERIOD=4.
- Reset: hold rst=0 for 3 cycles with key_valid pulses present → all outputs 0, no pulse on the first cycle after rst=1.
- Tap: Enter make at edge 10, break at edge 11 → key_C high only in the cycle after edge 11; key_C never fires again.
- Hold W: make at edge 10, break at edge 35 → key_U pulses after edges 11, 19, 23, 27, 31, 35. None after the break.
- Priority: S make and Enter make pending together (set on consecutive edges 10 and 11, arbiter stalled by a third request) → the C pulse precedes the D pulse. Outputs are never simultaneous; each key pulses exactly once.
- Retarget: hold A from edge 10, D make at edge 14 → no L repeat; R press pulse after edge 15, R repeat after edge 23.
- Break on terminal count: W make at edge 10, break at edge 18 → only the press pulse; no repeat pulse.

Source files
------------

// File: rtl/key_event_pkg.sv
// Shared definitions for the keyboard event conditioner.
//   - PS/2 set-2 scan codes of the five keys the game reacts to
//   - key index constants (also the arbiter priority order, lowest wins)
//   - repeat FSM state encoding
//   - key_code(): index -> scan code lookup used by the decoder loop
package key_event_pkg;

  localparam logic [8:0] SC_W     = 9'h01D;
  localparam logic [8:0] SC_S     = 9'h01B;
  localparam logic [8:0] SC_A     = 9'h01C;
  localparam logic [8:0] SC_D     = 9'h023;
  localparam logic [8:0] SC_ENTER = 9'h05A;

  localparam int NUM_KEYS = 5;

  // Index order doubles as grant priority: C > U > D > L > R.
  localparam logic [2:0] K_C = 3'd0;
  localparam logic [2:0] K_U = 3'd1;
  localparam logic [2:0] K_D = 3'd2;
  localparam logic [2:0] K_L = 3'd3;
  localparam logic [2:0] K_R = 3'd4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  function automatic logic [8:0] key_code(input int k);
    case (k)
      0:       key_code = SC_ENTER;
      1:       key_code = SC_W;
      2:       key_code = SC_S;
      3:       key_code = SC_A;
      default: key_code = SC_D;
    endcase
  endfunction

endpackage

// File: rtl/key_repeat_timer.sv
// Auto-repeat timer for the directional keys.
// Tracks the most recently pressed direction and raises rep_req for one
// cycle after HOLD_DELAY cycles of holding it, then every REPEAT_PERIOD
// cycles, until that key is released or another direction is pressed.
// Ports:
//   clk, rst      - clock, synchronous active-low reset
//   make[4:0]     - one-cycle make strobe per key index (index 0 ignored)
//   brk[4:0]      - one-cycle break strobe per key index
//   rep_req       - one-cycle repeat request for rep_key (combinational)
//   rep_key[2:0]  - key index currently being repeated (1..4)
module key_repeat_timer
  import key_event_pkg::*;
#(
  parameter int HOLD_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter int CNT_W         = 26
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] make,
  input  logic [NUM_KEYS-1:0] brk,
  output logic                rep_req,
  output logic [2:0]          rep_key
);

  logic [1:0]       rep_state;
  logic [CNT_W-1:0] cnt;
  logic             dir_make;
  logic [2:0]       make_idx;
  logic             rep_brk;
  logic             terminal;
  logic             unused_enter_make;

  // Enter never drives the repeat FSM.
  assign unused_enter_make = make[K_C];

  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    dir_make = 1'b0;
    make_idx = K_U;
    for (int k = 1; k < NUM_KEYS; k++) begin
      if (make[k] && !dir_make) begin
        dir_make = 1'b1;
        make_idx = 3'(k);
      end
    end
  end

  assign rep_brk  = brk[rep_key];
  assign terminal = ((rep_state == ST_DELAY)  && (cnt == CNT_W'(HOLD_DELAY - 1))) ||
                    ((rep_state == ST_REPEAT) && (cnt == CNT_W'(REPEAT_PERIOD - 1)));
  // A release of the repeated key or a retarget on the same edge as the
  // terminal count swallows that tick.
  assign rep_req  = terminal && !rep_brk && !dir_make;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rep_state <= ST_IDLE;
      cnt       <= '0;
      rep_key   <= K_U;
    end else if (dir_make) begin
      rep_key   <= make_idx;
      cnt       <= '0;
      rep_state <= ST_DELAY;
    end else if (rep_state == ST_DELAY || rep_state == ST_REPEAT) begin
      if (rep_brk) begin
        rep_state <= ST_IDLE;
        cnt       <= '0;
      end else if (terminal) begin
        rep_state <= ST_REPEAT;
        cnt       <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      rep_state <= ST_IDLE;
    end
  end

endmodule

// File: rtl/key_event_gen.sv
// Keyboard event conditioner: converts the PS/2 decoder's held-key bitmap
// and change strobe into single-cycle, mutually exclusive key pulses.
// Directional keys auto-repeat while held; Enter fires once per press.
// Ports:
//   clk, rst          - 100 MHz clock, synchronous active-low reset
//   key_valid         - decoder change strobe, one cycle per make/break
//   last_change[8:0]  - scan code of the key that just changed
//   key_down[511:0]   - decoder held-key bitmap
//   key_U/D/L/R/C     - registered one-cycle pulses (W/S/A/D/Enter)
module key_event_gen
  import key_event_pkg::*;
#(
  parameter int HOLD_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter int CNT_W         = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [8:0]   last_change,
  input  logic [511:0] key_down,
  output logic         key_U,
  output logic         key_D,
  output logic         key_L,
  output logic         key_R,
  output logic         key_C
);

  logic [NUM_KEYS-1:0] held;
  logic [NUM_KEYS-1:0] pending;
  logic [NUM_KEYS-1:0] make;
  logic [NUM_KEYS-1:0] brk;
  logic [NUM_KEYS-1:0] rep_set;
  logic [NUM_KEYS-1:0] grant;
  logic                rep_req;
  logic [2:0]          rep_key;
  logic                unused_bitmap;

  // Only five codes are decoded; the rest of the bitmap is deliberately ignored.
  assign unused_bitmap = ^key_down;

  // A make only counts on the first one; typematic re-makes of a held key
  // are dropped. A break clears held but leaves any pending tap pulse.
  always_comb begin
    make = '0;
    brk  = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (key_valid && (last_change == key_code(k))) begin
        if (key_down[key_code(k)]) make[k] = !held[k];
        else                       brk[k]  = 1'b1;
      end
    end
  end

  always_comb begin
    rep_set = '0;
    if (rep_req) rep_set[rep_key] = 1'b1;
  end

  // Isolate the lowest set pending bit: index 0 (Enter) has top priority.
  assign grant = pending & (~pending + NUM_KEYS'(1));

  key_repeat_timer #(
    .HOLD_DELAY    (HOLD_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD),
    .CNT_W         (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .make    (make),
    .brk     (brk),
    .rep_req (rep_req),
    .rep_key (rep_key)
  );

  // A request landing on a bit that is granted this same edge merges into
  // that grant rather than producing a second pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      held    <= '0;
      pending <= '0;
      key_C   <= 1'b0;
      key_U   <= 1'b0;
      key_D   <= 1'b0;
      key_L   <= 1'b0;
      key_R   <= 1'b0;
    end else begin
      held    <= (held | make) & ~brk;
      pending <= (pending | make | rep_set) & ~grant;
      key_C   <= grant[K_C];
      key_U   <= grant[K_U];
      key_D   <= grant[K_D];
      key_L   <= grant[K_L];
      key_R   <= grant[K_R];
    end
  end

endmodule

// File: tb/tb_key_event_gen.sv
// Scoreboard bench for key_event_gen with HOLD_DELAY=8, REPEAT_PERIOD=4.
// Stimulus pushes hand-computed (key, edge) pulses into a queue; an
// independent monitor pops one entry per observed pulse and compares.
// Edge numbering: cyc counts rising edges; a pulse "after edge N" is seen
// at the falling edge where cyc == N.
module tb_key_event_gen;
  import key_event_pkg::*;

  localparam int HOLD = 8;
  localparam int PER  = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         key_valid = 1'b0;
  logic [8:0]   last_change = '0;
  logic [511:0] key_down = '0;
  logic         key_U, key_D, key_L, key_R, key_C;
  logic [4:0]   outs;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int idx;
    int at;
  } exp_t;
  exp_t exp_q[$];

  key_event_gen #(
    .HOLD_DELAY    (HOLD),
    .REPEAT_PERIOD (PER),
    .CNT_W         (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .last_change (last_change),
    .key_down    (key_down),
    .key_U       (key_U),
    .key_D       (key_D),
    .key_L       (key_L),
    .key_R       (key_R),
    .key_C       (key_C)
  );

  assign outs = {key_R, key_L, key_D, key_U, key_C};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  // Monitor: every pulse must be one-hot and match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (outs !== 5'b0) begin
      check("onehot", {31'b0, $onehot(outs)}, 1);
      check("pulse_expected", (exp_q.size() > 0) ? 1 : 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pulse_key", {27'b0, outs}, 32'(1 << e.idx));
        check("pulse_edge", cyc, e.at);
      end
    end
  end

  // Quiet through reset and the first cycle after release.
  always @(negedge clk) begin
    if (cyc >= 1 && cyc <= 5) check("reset_quiet", {27'b0, outs}, 0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // Returns at the falling edge where cyc == e (caller must be at a falling edge).
  task automatic wait_to(input int e);
    if (cyc > e) begin
      $display("FAIL schedule: edge %0d already passed (now %0d)", e, cyc);
      $fatal(1, "stimulus schedule overrun");
    end
    while (cyc < e) @(negedge clk);
  endtask

  // Key event sampled at rising edge e.
  task automatic ev(input logic [8:0] code, input logic down, input int e);
    wait_to(e - 1);
    key_valid      = 1'b1;
    last_change    = code;
    key_down[code] = down;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic expect_pulse(input logic [2:0] idx, input int at);
    exp_q.push_back('{int'(idx), at});
  endtask

  task automatic drain(input int e);
    wait_to(e);
    check("queue_drained", exp_q.size(), 0);
  endtask

  int b;

  initial begin
    @(negedge clk);
    // Reset held low for edges 1..3 with decoder activity present.
    ev(SC_ENTER, 1'b1, 2);
    ev(SC_W, 1'b1, 3);
    key_down = '0;
    rst      = 1'b1;
    drain(8);

    // Tap Enter: one pulse only.
    b = cyc;
    expect_pulse(K_C, b + 11);
    ev(SC_ENTER, 1'b1, b + 10);
    ev(SC_ENTER, 1'b0, b + 11);
    drain(b + 30);

    // Hold W: press, then repeats at +8 and every +4 until the break.
    b = cyc;
    expect_pulse(K_U, b + 11);
    expect_pulse(K_U, b + 19);
    expect_pulse(K_U, b + 23);
    expect_pulse(K_U, b + 27);
    expect_pulse(K_U, b + 31);
    expect_pulse(K_U, b + 35);
    ev(SC_W, 1'b1, b + 10);
    ev(SC_W, 1'b0, b + 35);
    drain(b + 60);

    // Priority: W repeat and Enter make land together, S make follows while
    // both are still queued; C must win, then U, then D.
    b = cyc;
    expect_pulse(K_U, b + 12);
    expect_pulse(K_C, b + 20);
    expect_pulse(K_U, b + 21);
    expect_pulse(K_D, b + 22);
    ev(SC_W, 1'b1, b + 11);
    ev(SC_ENTER, 1'b1, b + 19);
    ev(SC_S, 1'b1, b + 20);
    ev(SC_S, 1'b0, b + 22);
    ev(SC_W, 1'b0, b + 23);
    ev(SC_ENTER, 1'b0, b + 24);
    drain(b + 50);

    // Retarget: A held, D pressed -> A never repeats, D repeats after +8.
    b = cyc;
    expect_pulse(K_L, b + 11);
    expect_pulse(K_R, b + 15);
    expect_pulse(K_R, b + 23);
    ev(SC_A, 1'b1, b + 10);
    ev(SC_D, 1'b1, b + 14);
    ev(SC_D, 1'b0, b + 24);
    ev(SC_A, 1'b0, b + 25);
    drain(b + 50);

    // Break on the terminal-count edge: no repeat.
    b = cyc;
    expect_pulse(K_U, b + 11);
    ev(SC_W, 1'b1, b + 10);
    ev(SC_W, 1'b0, b + 18);
    drain(b + 40);

    // Reset in mid-REPEAT: the repeat due at +14 and later ones vanish.
    b = cyc;
    expect_pulse(K_U, b + 3);
    expect_pulse(K_U, b + 11);
    ev(SC_W, 1'b1, b + 2);
    wait_to(b + 12);
    rst = 1'b0;
    wait_to(b + 13);
    check("mid_reset_quiet", {27'b0, outs}, 0);
    wait_to(b + 14);
    check("mid_reset_quiet", {27'b0, outs}, 0);
    rst = 1'b1;
    wait_to(b + 15);
    check("post_reset_quiet", {27'b0, outs}, 0);
    wait_to(b + 16);
    check("post_reset_quiet", {27'b0, outs}, 0);
    ev(SC_W, 1'b0, b + 17);
    drain(b + 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
